// File: rtl/uart_boot_loader.sv
// Purpose : UART 8N1 program loader; writes a checksummed frame of 16-bit words
//           into the program BSRAM from address 0 and then releases the CPU.
// Latency : memory write registered one cycle after the byte completing each word;
//           done/boot_mode update one cycle after the checksum byte.
// Backpressure: none; the UART line cannot be stalled, every byte is consumed on arrival.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rx                UART receive line (idle high, asynchronous)
//   mem_ad/mem_din    BSRAM write address / data
//   mem_wre/mem_ce    BSRAM write enable (1-cycle pulse) / chip enable (always 1)
//   boot_mode         1 while the loader owns memory, 0 once the CPU may run
//   done/err          sticky load-complete / frame-rejected flags
//   words_loaded      words written in the current or last frame
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 234,
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 16,
  parameter int TIMEOUT_CYC  = 2700000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wre,
  output logic              mem_ce,
  output logic              boot_mode,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CYC - 1);
  localparam logic [16:0]   MAX_LEN = 17'(2 ** ADDR_W);

  // ---------------------------------------------------------------- receiver
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;

  rx_state_t       rstate, rnext;
  logic            rx_s1, rx_s2, rx_d;
  logic [CW-1:0]   bit_cnt, cnt_n;
  logic [2:0]      bit_idx, idx_n;
  logic [7:0]      shreg, sh_n;
  logic            byte_valid, bv_n;
  logic            ferr, ferr_n;
  logic [7:0]      rx_byte;

  assign rx_byte = shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_d       <= 1'b1;
      rstate     <= R_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      ferr       <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_d       <= rx_s2;
      rstate     <= rnext;
      bit_cnt    <= cnt_n;
      bit_idx    <= idx_n;
      shreg      <= sh_n;
      byte_valid <= bv_n;
      ferr       <= ferr_n;
    end
  end

  always_comb begin
    rnext  = rstate;
    cnt_n  = bit_cnt + 1'b1;
    idx_n  = bit_idx;
    sh_n   = shreg;
    bv_n   = 1'b0;
    ferr_n = 1'b0;
    case (rstate)
      R_IDLE: begin
        cnt_n = '0;
        if (rx_d && !rx_s2) rnext = R_START;
      end
      R_START: begin
        // Mid-bit re-check rejects glitches shorter than half a bit.
        if (bit_cnt == HALF_M1) begin
          cnt_n = '0;
          idx_n = '0;
          rnext = rx_s2 ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (bit_cnt == FULL_M1) begin
          cnt_n = '0;
          sh_n  = {rx_s2, shreg[7:1]};
          idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rnext = R_STOP;
        end
      end
      R_STOP: begin
        if (bit_cnt == FULL_M1) begin
          cnt_n = '0;
          if (rx_s2) begin
            bv_n  = 1'b1;
            rnext = R_IDLE;
          end else begin
            ferr_n = 1'b1;
            rnext  = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        // Line held low after a bad stop bit: re-arm only once it idles high.
        cnt_n = '0;
        if (rx_s2) rnext = R_IDLE;
      end
      default: rnext = R_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ loader
  typedef enum logic [2:0] {SYNC, LEN_HI, LEN_LO, D_HI, D_LO, CSUM, DONE, ERR} ld_state_t;

  ld_state_t       state, nstate;
  logic [7:0]      len_hi, hi_byte, sum;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W-1:0] addr;
  logic [TW-1:0]   idle_cnt;
  logic [15:0]     len_full;
  logic [ADDR_W:0] wl_inc;
  logic            in_frame, timeout_hit, sync_hit;

  assign mem_ce      = 1'b1;
  assign len_full    = {len_hi, rx_byte};
  assign wl_inc      = words_loaded + 1'b1;
  assign in_frame    = (state == LEN_HI) || (state == LEN_LO) || (state == D_HI) ||
                       (state == D_LO) || (state == CSUM);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout_hit = in_frame && !byte_valid && (idle_cnt == TO_M1);
  assign sync_hit    = ((state == SYNC) || (state == ERR)) && byte_valid && (rx_byte == 8'hA5);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SYNC;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      SYNC, ERR: if (sync_hit) nstate = LEN_HI;
      LEN_HI:    if (byte_valid) nstate = LEN_LO;
      LEN_LO: begin
        if (byte_valid) begin
          if (len_full == 16'd0 || {1'b0, len_full} > MAX_LEN) nstate = ERR;
          else                                                 nstate = D_HI;
        end
      end
      D_HI:      if (byte_valid) nstate = D_LO;
      D_LO:      if (byte_valid) nstate = (wl_inc == len_q) ? CSUM : D_HI;
      CSUM:      if (byte_valid) nstate = (rx_byte == sum) ? DONE : ERR;
      DONE:      nstate = DONE;
      default:   nstate = SYNC;
    endcase
    if (in_frame && (ferr || timeout_hit)) nstate = ERR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ad       <= '0;
      mem_din      <= '0;
      mem_wre      <= 1'b0;
      boot_mode    <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      len_hi       <= '0;
      len_q        <= '0;
      hi_byte      <= '0;
      sum          <= '0;
      addr         <= '0;
      idle_cnt     <= '0;
    end else begin
      mem_wre <= 1'b0;
      if (!in_frame || byte_valid) idle_cnt <= '0;
      else                         idle_cnt <= idle_cnt + 1'b1;

      if (sync_hit) begin
        err          <= 1'b0;
        sum          <= '0;
        addr         <= '0;
        words_loaded <= '0;
      end

      if (byte_valid) begin
        case (state)
          LEN_HI: len_hi <= rx_byte;
          LEN_LO: len_q  <= len_full[ADDR_W:0];
          D_HI: begin
            hi_byte <= rx_byte;
            sum     <= sum + rx_byte;
          end
          D_LO: begin
            mem_din      <= {hi_byte, rx_byte};
            mem_ad       <= addr;
            mem_wre      <= 1'b1;
            addr         <= addr + 1'b1;
            words_loaded <= wl_inc;
            sum          <= sum + rx_byte;
          end
          default: ;
        endcase
      end

      if (nstate == ERR && state != ERR) err <= 1'b1;
      if (nstate == DONE && state == CSUM) begin
        done      <= 1'b1;
        boot_mode <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: drives UART frames (directed and $urandom) and
// compares memory writes and status flags against a frame-parsing reference model.
module tb_uart_boot_loader;

  localparam int CPB = 4;
  localparam int TO  = 200;

  typedef int stream_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [10:0] mem_ad;
  logic [15:0] mem_din;
  logic        mem_wre, mem_ce, boot_mode, done, err;
  logic [11:0] words_loaded;

  int n_vec = 0;
  int n_err = 0;

  // observed writes
  int got_ad[$];
  int got_din[$];
  int cyc = 0;
  int last_wre_cyc = 0;
  int wre_run = 0;

  // model outputs
  int m_ad[$];
  int m_din[$];
  bit m_done, m_err;
  int m_wl;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(11), .DATA_W(16), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .mem_ad(mem_ad), .mem_din(mem_din), .mem_wre(mem_wre), .mem_ce(mem_ce),
    .boot_mode(boot_mode), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (rst_n && mem_wre) begin
      got_ad.push_back(int'(mem_ad));
      got_din.push_back(int'(mem_din));
      last_wre_cyc = cyc;
      if (!boot_mode) wre_run++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int at(input stream_t s, input int idx);
    return (idx < s.size()) ? s[idx] : -2;
  endfunction

  // Parse the whole byte stream since reset: -1 marks a framing-error byte,
  // running off the end means an idle line (a timeout only if gap is set).
  function automatic void model(input stream_t s, input bit gap);
    int i, len, h, l, c, sum, code, pos;
    bit aborted;
    m_done = 0; m_err = 0; m_wl = 0;
    m_ad.delete(); m_din.delete();
    i = 0;
    while (i < s.size() && !m_done) begin
      if (s[i] != 'hA5) begin i++; continue; end
      i++; m_err = 0; m_wl = 0; sum = 0; aborted = 0; code = 0; pos = 0;
      h = at(s, i); l = at(s, i + 1);
      if (h < 0 || l < 0) begin
        aborted = 1; code = (h < 0) ? h : l; pos = (h < 0) ? i : i + 1;
      end else begin
        len = h * 256 + l; i += 2;
        if (len == 0 || len > 2048) begin m_err = 1; continue; end
        for (int w = 0; w < len; w++) begin
          h = at(s, i); l = at(s, i + 1);
          if (h < 0)      begin aborted = 1; code = h; pos = i;     break; end
          else if (l < 0) begin aborted = 1; code = l; pos = i + 1; break; end
          m_ad.push_back(w); m_din.push_back(h * 256 + l);
          m_wl++; sum += h + l; i += 2;
        end
        if (!aborted) begin
          c = at(s, i);
          if (c < 0) begin aborted = 1; code = c; pos = i; end
          else begin
            if (c == (sum & 255)) m_done = 1; else m_err = 1;
            i++;
          end
        end
      end
      if (aborted) begin
        if (code == -1) begin m_err = 1; i = pos + 1; end
        else begin m_err = gap; break; end
      end
    end
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    send_bit(1'b0);
    for (int k = 0; k < 8; k++) send_bit(b[k]);
    send_bit(!bad_stop);
    if (bad_stop) send_bit(1'b1);
  endtask

  task automatic send_stream(input stream_t s);
    int v;
    for (int k = 0; k < s.size(); k++) begin
      v = s[k];
      if (v < 0) send_byte(8'h55, 1'b1);
      else       send_byte(v[7:0], 1'b0);
    end
    repeat (10) @(posedge clk);
  endtask

  task automatic do_reset();
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    got_ad.delete(); got_din.delete();
    wre_run = 0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_result(input string tag, input stream_t s, input bit gap);
    model(s, gap);
    @(negedge clk); #1;
    chk({tag, ".done"}, done, m_done);
    chk({tag, ".err"}, err, m_err);
    chk({tag, ".boot"}, boot_mode, !m_done);
    chk({tag, ".wl"}, words_loaded, m_wl);
    chk({tag, ".wre_idle"}, mem_wre, 0);
    chk({tag, ".wre_run"}, wre_run, 0);
    chk({tag, ".nwr"}, got_ad.size(), m_ad.size());
    for (int k = 0; k < m_ad.size() && k < got_ad.size(); k++) begin
      chk($sformatf("%s.ad%0d", tag, k), got_ad[k], m_ad[k]);
      chk($sformatf("%s.din%0d", tag, k), got_din[k], m_din[k]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".ad"}, mem_ad, 0);
    chk({tag, ".din"}, mem_din, 0);
    chk({tag, ".wre"}, mem_wre, 0);
    chk({tag, ".ce"}, mem_ce, 1);
    chk({tag, ".boot"}, boot_mode, 1);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".wl"}, words_loaded, 0);
  endtask

  initial begin
    stream_t good, bad, s, extra;
    int len, sum, b, waited;

    good  = '{'hA5, 'h00, 'h02, 'h12, 'h34, 'hAB, 'hCD, 'hBE};
    bad   = '{'hA5, 'h00, 'h02, 'h12, 'h34, 'hAB, 'hCD, 'hBF};
    extra = '{'hA5, 'h00, 'h01, 'h11, 'h22, 'h33};

    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    do_reset();

    // good frame, then a second frame that must be ignored after done
    send_stream(good);
    check_result("good", good, 0);
    chk("good.din0_lit", (got_din.size() > 0) ? got_din[0] : -1, 'h1234);
    s = good;
    foreach (extra[k]) s.push_back(extra[k]);
    send_stream(extra);
    check_result("after_done", s, 0);

    // bad checksum, then retry
    do_reset();
    send_stream(bad);
    check_result("badsum", bad, 0);
    send_stream(good);
    s = bad;
    foreach (good[k]) s.push_back(good[k]);
    check_result("retry", s, 0);

    // noise and an idle glitch before a good frame
    do_reset();
    @(posedge clk); rx = 1'b0;
    @(posedge clk); rx = 1'b1;
    repeat (20) @(posedge clk);
    s = '{'h00, 'hFF, 'h5A};
    foreach (good[k]) s.push_back(good[k]);
    send_stream(s);
    check_result("noise", s, 0);

    // length checks
    do_reset();
    s = '{'hA5, 'h00, 'h00};
    send_stream(s);
    check_result("len0", s, 0);
    do_reset();
    s = '{'hA5, 'h08, 'h01};
    send_stream(s);
    check_result("len2049", s, 0);

    // framing error mid-frame
    do_reset();
    s = '{'hA5, 'h00, 'h01, 'h12, -1};
    send_stream(s);
    check_result("ferr", s, 0);

    // inter-byte timeout, exact expiry position
    do_reset();
    s = '{'hA5, 'h00, 'h02, 'h12, 'h34};
    send_stream(s);
    waited = 0;
    while (cyc < last_wre_cyc + TO - 1 && waited < 400) begin
      @(negedge clk); #1; waited++;
    end
    chk("to.err_before", err, 0);
    @(negedge clk); #1;
    chk("to.err_at", err, 1);
    repeat (50) @(posedge clk);
    check_result("timeout", s, 1);

    // reset asserted during D_LO of the second word
    do_reset();
    s = '{'hA5, 'h00, 'h03, 'h12, 'h34, 'h56};
    send_stream(s);
    #1;
    chk("midrst.wl_pre", words_loaded, 1);
    chk("midrst.din_pre", mem_din, 'h1234);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(posedge clk);

    // randomized frames: random noise prefix, length, data, checksum validity
    for (int it = 0; it < 6; it++) begin
      do_reset();
      s.delete();
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        b = $urandom_range(0, 255);
        s.push_back((b == 'hA5) ? 0 : b);
      end
      len = $urandom_range(1, 5);
      s.push_back('hA5); s.push_back(0); s.push_back(len);
      sum = 0;
      for (int k = 0; k < 2 * len; k++) begin
        b = $urandom_range(0, 255);
        s.push_back(b); sum += b;
      end
      if ($urandom_range(0, 1) == 1) s.push_back(sum & 255);
      else s.push_back((sum + 1 + $urandom_range(0, 254)) & 255);
      send_stream(s);
      check_result($sformatf("rnd%0d", it), s, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Upstream stage of the program BSRAM (Gowin_SP). Receives a program image over a UART 8N1 line and writes it as 16-bit instruction words starting at address 0.
- Holds boot_mode high while loading. boot_mode drives the top-level address mux and keeps the CPU out of fetch. It drops once a frame with a valid checksum completes.
- Replaces the hard-coded boot_data table with host-downloadable programs.

Parameters:
- CLKS_PER_BIT, 234, clk cycles per UART bit (27 MHz / 115200); minimum 4.
- ADDR_W, 11, BSRAM address width.
- DATA_W, 16, instruction word width; fixed at 16 (two bytes per word).
- TIMEOUT_CYC, 2700000, maximum idle clk cycles between bytes inside a frame (100 ms).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  UART receive line, idle high, asynchronous to clk
- mem_ad  out  ADDR_W  BSRAM write address
- mem_din  out  DATA_W  BSRAM write data
- mem_wre  out  1  BSRAM write enable, one-cycle pulse per word
- mem_ce  out  1  BSRAM chip enable, constant 1 out of reset
- boot_mode  out  1  1 = loader owns memory and CPU is held; 0 = CPU runs
- done  out  1  sticky, high after a successful load
- err  out  1  sticky until the next sync byte; frame rejected
- words_loaded  out  ADDR_W+1  words written in the current/last frame

Behaviour:
- Reset values: mem_ad=0, mem_din=0, mem_wre=0, mem_ce=1, boot_mode=1, done=0, err=0, words_loaded=0, FSM in SYNC. Reset asserted mid-load aborts immediately. BSRAM contents already written are not cleared.
- RX front end:
  - rx passes through a 2-flop synchronizer, which adds 2 cycles of latency.
  - Start detection: a high-to-low transition of the synchronized rx.
  - Start bit is re-sampled at CLKS_PER_BIT/2. If rx is high there, it is a false start and the receiver returns to idle with no byte.
  - Data bits are sampled every CLKS_PER_BIT after that, LSB first. The stop bit is sampled one bit later.
  - Stop=1: byte_valid pulses for 1 cycle at the stop sample.
  - Stop=0: ferr pulses for 1 cycle and no byte is produced. The receiver waits for rx high before re-arming.
- Frame format, in bytes: 0xA5, LEN_HI, LEN_LO, then for each word (HI, LO), then CSUM.
  - LEN is the count of 16-bit words.
  - CSUM = 8-bit sum (mod 256) of all data bytes. LEN bytes are excluded.
- Loader FSM states: SYNC, LEN_HI, LEN_LO, D_HI, D_LO, CSUM, DONE, ERR.
  - SYNC:
    - A byte of 0xA5 clears err, sum, the address counter and words_loaded, then moves to LEN_HI.
    - Any other byte, and any ferr, is ignored.
  - LEN_HI → LEN_LO: latch the byte.
  - LEN_LO:
    - If LEN==0 or LEN > 2**ADDR_W → ERR.
    - Otherwise → D_HI.
  - D_HI: latch the high byte, add it to sum, → D_LO.
  - D_LO: on the byte_valid cycle, register these outputs for the next cycle:
    - mem_din={hi,lo}, mem_ad=addr, mem_wre=1 for exactly 1 cycle;
    - addr+1, words_loaded+1, sum updated.
    - If words_loaded+1 == LEN → CSUM; otherwise → D_HI.
    - The address wraps only via the LEN check, so it never exceeds 2**ADDR_W-1.
  - CSUM:
    - Byte == sum → DONE.
    - Otherwise → ERR.
  - DONE:
    - boot_mode=0 and done=1 in the cycle after the CSUM byte_valid.
    - Terminal until reset; all further rx activity is ignored and mem_wre stays 0.
  - ERR:
    - err=1 and boot_mode stays 1. Transitions immediately to SYNC behaviour, so the next 0xA5 restarts the load at address 0.
- Errors entering ERR from any in-frame state (LEN_HI..CSUM): ferr, or TIMEOUT_CYC clk cycles with no byte_valid. The idle counter resets on every byte_valid.
- A byte_valid coinciding with a timeout expiry: the byte is taken and the timeout is cleared.
- mem_wre is never high while boot_mode=0.

Test Plan:
- Use CLKS_PER_BIT=4 and TIMEOUT_CYC=200 for simulation.
- Good frame: send A5 00 02 12 34 AB CD BE → 2 mem_wre pulses, (ad 0, din 16'h1234) then (ad 1, din 16'hABCD); then words_loaded=2, done=1, boot_mode=0, err=0.
- Bad checksum: same frame with CSUM BF → err=1, done=0, boot_mode=1; then resend the good frame → err clears on A5, done=1, words_loaded=2.
- Noise and sync: send 00 FF 5A followed by the good frame, plus a 1-cycle low glitch on rx while idle → no byte or write from the noise; good-frame result as in the first scenario.
- Length checks:
  - A5 00 00 → err=1 after LEN_LO with no writes.
  - A5 08 01 (LEN=2049) → err=1.
- Framing error mid-frame: A5 00 01 12 followed by a byte with stop bit 0 → err=1, only 0 writes, boot_mode=1.
- Timeout, then reset mid-load:
  - A5 00 02 12 34, then rx idle for 250 cycles → err=1 after exactly 200 idle cycles past the last stop sample.
  - Separately, asserting rst_n low during D_LO → all outputs return to reset values.
